// File: rtl/tinker_mem_pkg.sv
// Shared widths, FSM states and owner encoding for the Tinker unified-memory arbiter.
package tinker_mem_pkg;

  localparam int TINKER_ADDR_W = 64;
  localparam int TINKER_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  function automatic arb_owner_e other_owner(input arb_owner_e o);
    return (o == OWN_IF) ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/tinker_mem_arbiter_pick.sv
// Grant selection for the memory arbiter; owns the priority state register.
// MEM_ARB_RR_EN selects round-robin, otherwise fixed D priority with IF starvation relief.
module mem_arb_pick
  import tinker_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);

  logic conflict;
  assign conflict = if_valid && d_valid;

`ifdef MEM_ARB_RR_EN
  arb_owner_e rr_ptr_q, rr_ptr_d;

  // The pointer names the side preferred on the next conflict.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (arb_en) begin
      if (conflict) begin
        grant_if = (rr_ptr_q == OWN_IF);
        grant_d  = (rr_ptr_q == OWN_D);
      end else begin
        grant_if = if_valid;
        grant_d  = d_valid;
      end
      if (grant_if) begin
        rr_ptr_d = other_owner(OWN_IF);
      end else if (grant_d) begin
        rr_ptr_d = other_owner(OWN_D);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= OWN_D;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    starve_d = starve_q;
    if (arb_en) begin
      if (conflict) begin
        grant_if = (starve_q == STARVE_LIM);
        grant_d  = (starve_q != STARVE_LIM);
      end else begin
        grant_if = if_valid;
        grant_d  = d_valid;
      end
      // Only conflicts lost by IF count toward starvation.
      if (grant_if) begin
        starve_d = '0;
      end else if (grant_d && conflict && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Arbitrates the single Tinker memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin conflict resolution instead of fixed D priority.
module tinker_mem_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W     = TINKER_ADDR_W,
  parameter int DATA_W     = TINKER_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("tinker_mem_arbiter: MEM_LAT must be at least 1");
  end

  localparam int LW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              we_q, we_d;
  logic [LW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]       if_rsp_data_q, if_rsp_data_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_W-1:0] d_rsp_data_q, d_rsp_data_d;

  logic accept_en;
  logic grant_if;
  logic grant_d;

  // Requests are only taken in IDLE and never while reset is asserted.
  assign accept_en = reset && (state_q == IDLE);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .arb_en   (accept_en),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    we_d           = we_q;
    wait_cnt_d     = wait_cnt_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    d_rsp_valid_d  = 1'b0;
    d_rsp_data_d   = d_rsp_data_q;

    case (state_q)
      IDLE: begin
        if (grant_if || grant_d) begin
          state_d     = ACCESS;
          owner_d     = grant_if ? OWN_IF : OWN_D;
          we_d        = grant_d && d_req_we;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_d && d_req_we;
          mem_addr_d  = grant_if ? if_addr : d_addr;
          mem_wdata_d = grant_d ? d_wdata : '0;
        end
      end
      ACCESS: begin
        state_d    = WAIT;
        wait_cnt_d = LW'(MEM_LAT);
      end
      WAIT: begin
        // Last WAIT cycle is exactly MEM_LAT cycles after the strobe.
        if (wait_cnt_q == LW'(1)) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = mem_rdata[31:0];
          end else begin
            d_rsp_valid_d = 1'b1;
            d_rsp_data_d  = we_q ? '0 : mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - LW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      we_q           <= 1'b0;
      wait_cnt_q     <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_data_q   <= d_rsp_data_d;
    end
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q != IDLE);

  // A requester that has raised valid must keep it until it sees ready.
  a_if_no_withdraw: assert property (@(posedge clk) disable iff (!reset)
    (if_req_valid && !if_req_ready) |=> if_req_valid);
  a_d_no_withdraw: assert property (@(posedge clk) disable iff (!reset)
    (d_req_valid && !d_req_ready) |=> d_req_valid);
  a_we_with_en: assert property (@(posedge clk) disable iff (!reset)
    mem_we |-> mem_en);

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Self-checking bench for tinker_mem_arbiter: cycle model plus directed literal checks.
// Honours MEM_ARB_RR_EN for the expected conflict order.
module tb_tinker_mem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int SMAX = 4;
  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance (MEM_LAT=1)
  logic          if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_rsp_data;
  logic          d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0, d_rsp_valid;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rsp_data;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Second instance (MEM_LAT=3), fetch only
  logic          if_req_valid_3 = 1'b0, if_req_ready_3, if_rsp_valid_3;
  logic [AW-1:0] if_addr_3 = '0;
  logic [31:0]   if_rsp_data_3;
  logic          d_req_ready_3, d_rsp_valid_3;
  logic [DW-1:0] d_rsp_data_3;
  logic          mem_en_3, mem_we_3, busy_3;
  logic [AW-1:0] mem_addr_3;
  logic [DW-1:0] mem_wdata_3, mem_rdata_3;

  tinker_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  tinker_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid_3), .if_req_ready(if_req_ready_3), .if_addr(if_addr_3),
    .if_rsp_valid(if_rsp_valid_3), .if_rsp_data(if_rsp_data_3),
    .d_req_valid(1'b0), .d_req_ready(d_req_ready_3), .d_req_we(1'b0),
    .d_addr(64'h0), .d_wdata(64'h0), .d_rsp_valid(d_rsp_valid_3), .d_rsp_data(d_rsp_data_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  function automatic int idx(input logic [63:0] a);
    return int'(a[15:3]);
  endfunction

  // Power-on memory contents, shared definition of the environment.
  function automatic logic [63:0] init_val(input logic [63:0] a);
    if (a == 64'h2000) return 64'hDEAD_BEEF_1234_5678;
    return {~a[31:0], a[31:0]} ^ 64'h5A5A_0000_0000_5A5A;
  endfunction

  // Byte-memory environment for the main instance (read latency 1).
  bit [63:0] env_mem [0:8191];
  bit        env_wr_v [0:8191];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      env_mem[idx(mem_addr)]  <= mem_wdata;
      env_wr_v[idx(mem_addr)] <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= env_wr_v[idx(mem_addr)] ? env_mem[idx(mem_addr)] : init_val(mem_addr);
    else
      mem_rdata <= BAD;
  end

  // Environment for the latency-3 instance.
  logic [63:0] p0 = BAD, p1 = BAD, p2 = BAD;
  always @(posedge clk) begin
    p0 <= mem_en_3 ? init_val(mem_addr_3) : BAD;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata_3 = p2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_on = 1'b0;
  int          age = 0;          // cycles since acceptance, 0 = idle
  int          own_m = 0;        // 0 = IF, 1 = D
  bit          we_m = 1'b0;
  logic [63:0] addr_m = '0, wdata_m = '0;
  int          starve_m = 0;
  int          ptr_m = 1;
  bit [63:0]   shadow [0:8191];
  bit          shadow_v [0:8191];
  int          grant_log[$];
  int          dut_log[$];

  function automatic logic [63:0] model_read(input logic [63:0] a);
    return shadow_v[idx(a)] ? shadow[idx(a)] : init_val(a);
  endfunction

  always @(negedge clk) begin : compare
    int gnt;
    bit both;
    logic [63:0] mv;
    if (model_on) begin
      gnt = -1;
      both = 1'b0;
      if (reset && age == 0) begin
        both = if_req_valid && d_req_valid;
`ifdef MEM_ARB_RR_EN
        if (both) gnt = ptr_m;
`else
        if (both) gnt = (starve_m == SMAX) ? 0 : 1;
`endif
        else if (if_req_valid) gnt = 0;
        else if (d_req_valid) gnt = 1;
      end
      if (if_req_ready) dut_log.push_back(0);
      else if (d_req_ready) dut_log.push_back(1);

      chk("if_req_ready", 64'(if_req_ready), 64'(gnt == 0));
      chk("d_req_ready", 64'(d_req_ready), 64'(gnt == 1));
      chk("mem_en", 64'(mem_en), 64'(age == 1));
      chk("mem_we", 64'(mem_we), 64'(age == 1 && we_m));
      chk("mem_addr", mem_addr, addr_m);
      if (age == 1 && we_m) chk("mem_wdata", mem_wdata, wdata_m);
      chk("busy", 64'(busy), 64'(age != 0));
      chk("if_rsp_valid", 64'(if_rsp_valid), 64'(age == LAT + 2 && own_m == 0));
      chk("d_rsp_valid", 64'(d_rsp_valid), 64'(age == LAT + 2 && own_m == 1));
      chk("rsp_exclusive", 64'(if_rsp_valid && d_rsp_valid), 64'h0);
      if (age == LAT + 2 && own_m == 0) begin
        mv = model_read(addr_m);
        chk("if_rsp_data", 64'(if_rsp_data), {32'h0, mv[31:0]});
        $display("txn IF  addr=0x%0h data=0x%0h", addr_m, if_rsp_data);
      end
      if (age == LAT + 2 && own_m == 1) begin
        mv = we_m ? 64'h0 : model_read(addr_m);
        chk("d_rsp_data", d_rsp_data, mv);
        $display("txn D   addr=0x%0h we=%0d data=0x%0h", addr_m, we_m, d_rsp_data);
      end

      if (!reset) begin
        age = 0; starve_m = 0; ptr_m = 1; addr_m = '0; we_m = 1'b0;
      end else if (age == 0) begin
        if (gnt >= 0) begin
          grant_log.push_back(gnt);
          age = 1;
          own_m = gnt;
          if (gnt == 0) begin
            we_m = 1'b0;
            addr_m = if_addr;
          end else begin
            we_m = d_req_we;
            addr_m = d_addr;
            wdata_m = d_wdata;
            if (d_req_we) begin
              shadow[idx(d_addr)] = d_wdata;
              shadow_v[idx(d_addr)] = 1'b1;
            end
          end
`ifdef MEM_ARB_RR_EN
          ptr_m = (gnt == 0) ? 1 : 0;
`else
          if (gnt == 0) starve_m = 0;
          else if (both && starve_m < SMAX) starve_m++;
`endif
        end
      end else if (age == LAT + 2) begin
        age = 0;
      end else begin
        age++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_hs(input bit is_if, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_if ? if_req_ready : d_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, ".handshake"}, 64'(ok), 64'h1);
  endtask

  task automatic run_if_basic(input string tag);
    if_addr = 64'h2000;
    if_req_valid = 1'b1;
    wait_hs(1'b1, tag);
    @(posedge clk); #1 if_req_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".mem_en"}, 64'(mem_en), 64'h1);
    chk({tag, ".mem_we"}, 64'(mem_we), 64'h0);
    chk({tag, ".mem_addr"}, mem_addr, 64'h2000);
    chk({tag, ".busy1"}, 64'(busy), 64'h1);
    @(negedge clk);
    chk({tag, ".early_rsp"}, 64'(if_rsp_valid), 64'h0);
    @(negedge clk);
    chk({tag, ".rsp_valid"}, 64'(if_rsp_valid), 64'h1);
    chk({tag, ".rsp_data"}, 64'(if_rsp_data), 64'h1234_5678);
    chk({tag, ".busy3"}, 64'(busy), 64'h1);
    @(negedge clk);
    chk({tag, ".busy4"}, 64'(busy), 64'h0);
  endtask

  task automatic run_d(input string tag, input bit we, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] exp_rsp);
    d_req_we = we; d_addr = a; d_wdata = wd;
    d_req_valid = 1'b1;
    wait_hs(1'b0, tag);
    @(posedge clk); #1 d_req_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".mem_en"}, 64'(mem_en), 64'h1);
    chk({tag, ".mem_we"}, 64'(mem_we), 64'(we));
    if (we) chk({tag, ".mem_wdata"}, mem_wdata, wd);
    @(negedge clk);
    chk({tag, ".mem_we_off"}, 64'(mem_we), 64'h0);
    @(negedge clk);
    chk({tag, ".rsp_valid"}, 64'(d_rsp_valid), 64'h1);
    chk({tag, ".rsp_data"}, d_rsp_data, exp_rsp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int exp_seq[10];
    int n;
    int guard;
    bit w_if;
    @(posedge clk); #1 model_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'h0);
    chk("rst.mem_en", 64'(mem_en), 64'h0);
    chk("rst.mem_addr", mem_addr, 64'h0);
    chk("rst.if_rsp_data", 64'(if_rsp_data), 64'h0);
    chk("rst.d_rsp_data", d_rsp_data, 64'h0);

    run_if_basic("t1");
    run_d("t2.store", 1'b1, 64'h1000, 64'hA5A5_0000_FFFF_0001, 64'h0);
    run_d("t2.load", 1'b0, 64'h1000, 64'h0, 64'hA5A5_0000_FFFF_0001);

    // Conflict ordering from a clean priority state
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_seq = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    grant_log.delete();
    dut_log.delete();
    if_addr = 64'h3000; d_addr = 64'h3100; d_req_we = 1'b0;
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    n = 0; guard = 0; w_if = 1'b0;
    while (n < 10 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (if_req_ready || d_req_ready) begin
        w_if = if_req_ready;
        n++;
        @(posedge clk); #1;
        if (w_if) if_addr = if_addr + 64'd8;
        else d_addr = d_addr + 64'd8;
      end
    end
    chk("t3.grants_done", 64'(n), 64'd10);
    if (w_if) if_req_valid = 1'b0;
    else d_req_valid = 1'b0;
    wait_hs(!w_if, "t3.tail");
    @(posedge clk); #1 if_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3.dut_grant%0d", i),
          64'((i < dut_log.size()) ? dut_log[i] : -1), 64'(exp_seq[i]));
      chk($sformatf("t3.model_grant%0d", i),
          64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(exp_seq[i]));
    end

    // Reset asserted while the transaction sits in WAIT
    if_addr = 64'h2000; if_req_valid = 1'b1;
    wait_hs(1'b1, "t5");
    @(posedge clk); #1 if_req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5.busy", 64'(busy), 64'h0);
    chk("t5.mem_en", 64'(mem_en), 64'h0);
    chk("t5.mem_addr", mem_addr, 64'h0);
    chk("t5.if_rsp_valid", 64'(if_rsp_valid), 64'h0);
    chk("t5.if_rsp_data", 64'(if_rsp_data), 64'h0);
    chk("t5.d_rsp_data", d_rsp_data, 64'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("t5.no_late_rsp", 64'(if_rsp_valid), 64'h0);
    run_if_basic("t5b");

    // Latency-3 instance, fetch only, second request held from T+1
    if_addr_3 = 64'h2000; if_req_valid_3 = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_req_ready_3) begin
        n = 1;
        break;
      end
    end
    chk("t6.handshake", 64'(n), 64'h1);
    @(posedge clk); #1 if_addr_3 = 64'h2008;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t6.mem_en@T+%0d", k), 64'(mem_en_3), 64'(k == 1));
      chk($sformatf("t6.rsp_valid@T+%0d", k), 64'(if_rsp_valid_3), 64'(k == 5));
      chk($sformatf("t6.ready@T+%0d", k), 64'(if_req_ready_3), 64'(k == 6));
      if (k == 1) chk("t6.mem_addr", mem_addr_3, 64'h2000);
      if (k == 5) begin
        chk("t6.rsp_data", 64'(if_rsp_data_3), 64'h1234_5678);
        $display("txn IF3 addr=0x2000 data=0x%0h", if_rsp_data_3);
      end
    end
    @(posedge clk); #1 if_req_valid_3 = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6.idle", 64'(busy_3), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
